// File: rtl/stage_flow_ctrl_if.sv
// Handshake bundle for one match-action stage: PHV in/out with
// valid/ready, plus the control AXI-Stream pass-through (in and out).
// The slave modport is the stage's view; master is the environment's.
interface stage_flow_ctrl_if #(
   parameter int PHV_LEN = 1124,
   parameter int DATA_W  = 512,
   parameter int USER_W  = 128
);
   localparam int KEEP_W = DATA_W / 8;

   logic [PHV_LEN-1:0] phv_in;
   logic               phv_in_valid;
   logic               stg_ready;
   logic [PHV_LEN-1:0] phv_out;
   logic               phv_out_valid;
   logic               phv_out_ready;

   logic [DATA_W-1:0]  c_s_axis_tdata;
   logic [USER_W-1:0]  c_s_axis_tuser;
   logic [KEEP_W-1:0]  c_s_axis_tkeep;
   logic               c_s_axis_tvalid;
   logic               c_s_axis_tlast;

   logic [DATA_W-1:0]  c_m_axis_tdata;
   logic [USER_W-1:0]  c_m_axis_tuser;
   logic [KEEP_W-1:0]  c_m_axis_tkeep;
   logic               c_m_axis_tvalid;
   logic               c_m_axis_tlast;

   modport slave (
      input  phv_in, phv_in_valid, phv_out_ready,
      input  c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tvalid, c_s_axis_tlast,
      output stg_ready, phv_out, phv_out_valid,
      output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
   );

   modport master (
      output phv_in, phv_in_valid, phv_out_ready,
      output c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tvalid, c_s_axis_tlast,
      input  stg_ready, phv_out, phv_out_valid,
      input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast
   );
endinterface

// File: rtl/stage_flow_ctrl.sv
// Stage flow controller: buffers PHVs in a small FWFT FIFO, stamps the
// stage-visit mark bit unless in bypass, counts marked PHVs, and filters
// the control stream -- packets addressed to this stage are consumed and
// decoded as configuration, all others are forwarded one cycle later.
module stage_flow_ctrl #(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int STAGE_ID             = 0,
   parameter int PHV_LEN              = 1124,
   parameter int FIFO_DEPTH           = 4,
   parameter int MARK_OFF             = 0
) (
   input  logic                          axis_clk,
   input  logic                          aresetn,
   stage_flow_ctrl_if.slave              bus,
   output logic                          bypass,
   output logic [31:0]                   pkt_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int LVL_W    = PTR_W + 1;
   localparam int KEEP_W   = C_S_AXIS_DATA_WIDTH / 8;
   localparam int MARK_IDX = MARK_OFF + STAGE_ID;

   typedef enum logic [1:0] {IDLE, FWD, DROP} ctrl_state_e;

   // PHV buffer
   logic [PHV_LEN-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [LVL_W-1:0]   level_q;
   logic [PHV_LEN-1:0] phv_wr;
   logic               ready, out_valid, push, pop;

   // Configuration / statistics
   logic               bypass_q;
   logic [31:0]        cnt_q;

   // Control stream
   ctrl_state_e                     state;
   logic                            id_match, cfg_hit, cfg_set_byp, cfg_clr, fwd_beat;
   logic [C_S_AXIS_DATA_WIDTH-1:0]  m_tdata;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] m_tuser;
   logic [KEEP_W-1:0]               m_tkeep;
   logic                            m_tvalid, m_tlast;

   assign ready     = (level_q != LVL_W'(FIFO_DEPTH));
   assign out_valid = (level_q != '0);
   assign push      = bus.phv_in_valid && ready;
   assign pop       = out_valid && bus.phv_out_ready;

   assign bus.stg_ready     = ready;
   assign bus.phv_out_valid = out_valid;
   assign bus.phv_out       = out_valid ? mem[rd_ptr] : '0;

   // Stamp the visit mark unless this stage is bypassed (old bypass value applies).
   always_comb begin
      // NOTE: default first so every path assigns phv_wr and no latch is inferred.
      phv_wr = bus.phv_in;
      if (!bypass_q) phv_wr[MARK_IDX] = 1'b1;
   end

   // Buffer storage write.
   // NOTE: storage is not reset; the occupancy count alone decides what is valid.
   always_ff @(posedge axis_clk) begin
      if (push) mem[wr_ptr] <= phv_wr;
   end

   // Pointers and occupancy; pointers wrap naturally since depth is a power of 2.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      // NOTE: registered state uses non-blocking assignment throughout.
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // First-beat decode: only a packet start in IDLE addressed to us is a command.
   assign id_match    = (bus.c_s_axis_tdata[7:0] == 8'(STAGE_ID));
   assign cfg_hit     = (state == IDLE) && bus.c_s_axis_tvalid && id_match;
   assign cfg_set_byp = cfg_hit && (bus.c_s_axis_tdata[15:8] == 8'h01);
   assign cfg_clr     = cfg_hit && (bus.c_s_axis_tdata[15:8] == 8'h02);
   assign fwd_beat    = bus.c_s_axis_tvalid &&
                        (((state == IDLE) && !id_match) || (state == FWD));

   // Bypass mode and marked-PHV counter; a clear wins over a same-cycle increment.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         bypass_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (cfg_set_byp) bypass_q <= bus.c_s_axis_tdata[16];
         if (cfg_clr)                 cnt_q <= '0;
         else if (push && !bypass_q)  cnt_q <= cnt_q + 1'b1;
      end
   end

   // Control packet FSM with registered forwarding outputs.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         m_tdata  <= '0;
         m_tuser  <= '0;
         m_tkeep  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
      end else begin
         if (fwd_beat) begin
            m_tdata  <= bus.c_s_axis_tdata;
            m_tuser  <= bus.c_s_axis_tuser;
            m_tkeep  <= bus.c_s_axis_tkeep;
            m_tlast  <= bus.c_s_axis_tlast;
            m_tvalid <= 1'b1;
         end else begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
         end
         if (bus.c_s_axis_tvalid) begin
            case (state)
               IDLE: if (!bus.c_s_axis_tlast) state <= id_match ? DROP : FWD;
               FWD,
               DROP: if (bus.c_s_axis_tlast) state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.c_m_axis_tdata  = m_tdata;
   assign bus.c_m_axis_tuser  = m_tuser;
   assign bus.c_m_axis_tkeep  = m_tkeep;
   assign bus.c_m_axis_tvalid = m_tvalid;
   assign bus.c_m_axis_tlast  = m_tlast;

   assign bypass     = bypass_q;
   assign pkt_cnt    = cnt_q;
   assign fifo_level = level_q;
endmodule
